// File: rtl/breath_led_pkg.sv
// Shared defaults and types for the breathing-LED driver.
package breath_led_pkg;

    // 1024-clock PWM period (20.48 us at 50 MHz)
    localparam int PWM_BITS_DEF     = 10;
    // PWM periods per duty step; about 0.52 s per full ramp at defaults
    localparam int STEP_PERIODS_DEF = 25;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

endpackage

// File: rtl/breath_led_pwm.sv
// PWM generator: free-running period counter, duty compare and registered LED.
// period_tick_o is high in the last cycle of each period. The parent updates
// duty on that same edge, so every period sees a single duty value.
module breath_led_pwm #(
    parameter int PWM_BITS = 10
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                enable_i,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic                led_o,
    output logic                period_tick_o
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                led_q, led_d;

    // Next state: count and compare while enabled; otherwise hold and blank.
    // The compare uses the pre-increment count.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q;
        led_d     = 1'b0;
        if (enable_i) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
            led_d     = (pwm_cnt_q < duty_i);
        end
    end

    // Counter and LED registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pwm_cnt_q <= '0;
            led_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign period_tick_o = enable_i && (pwm_cnt_q == CNT_MAX);
    assign led_o         = led_q;

endmodule

// File: rtl/breath_led.sv
// Breathing-LED driver: ramps PWM duty 0..MAX..0 continuously, one step every
// STEP_PERIODS PWM periods. enable=0 freezes all state and blanks the LED.
module breath_led
    import breath_led_pkg::*;
#(
    parameter int PWM_BITS     = PWM_BITS_DEF,
    parameter int STEP_PERIODS = STEP_PERIODS_DEF
) (
    input  logic CLK_50MHz,
    input  logic reset_n,
    input  logic enable,
    output logic led
);

    // A one-bit step counter still works when STEP_PERIODS is 1: it stays at 0.
    localparam int                  STEP_W    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    dir_t                dir_q, dir_d;
    logic                period_tick;

    breath_led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk_i         (CLK_50MHz),
        .rst_n_i       (reset_n),
        .enable_i      (enable),
        .duty_i        (duty_q),
        .led_o         (led),
        .period_tick_o (period_tick)
    );

    // Step counting and triangle duty update. Each endpoint turns around
    // directly to its neighbour, so it is visited only once per turnaround.
    always_comb begin
        step_cnt_d = step_cnt_q;
        duty_d     = duty_q;
        dir_d      = dir_q;
        if (period_tick) begin
            if (step_cnt_q == STEP_LAST) begin
                step_cnt_d = '0;
                if (dir_q == DIR_UP) begin
                    if (duty_q == DUTY_MAX) begin
                        dir_d  = DIR_DOWN;
                        duty_d = DUTY_MAX - DUTY_ONE;
                    end else begin
                        duty_d = duty_q + DUTY_ONE;
                    end
                end else begin
                    if (duty_q == '0) begin
                        dir_d  = DIR_UP;
                        duty_d = DUTY_ONE;
                    end else begin
                        duty_d = duty_q - DUTY_ONE;
                    end
                end
            end else begin
                step_cnt_d = step_cnt_q + 1'b1;
            end
        end
    end

    // Step counter, duty and direction registers; reset restarts the ramp upward
    always_ff @(posedge CLK_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            step_cnt_q <= '0;
            duty_q     <= '0;
            dir_q      <= DIR_UP;
        end else begin
            step_cnt_q <= step_cnt_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
        end
    end

endmodule

// File: tb/tb_breath_led.sv
// Self-checking bench for breath_led: three instances with different
// parameters share one 50 MHz clock and are exercised one after another.
module tb_breath_led;
    import breath_led_pkg::*;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic en_a, en_b, en_c;
    logic led_a, led_b, led_c;

    // Small ramp: 16-clock periods, 2 periods per step
    breath_led #(.PWM_BITS(4), .STEP_PERIODS(2)) dut_a (
        .CLK_50MHz(clk), .reset_n(rst_a), .enable(en_a), .led(led_a));
    // Fastest stepping: 8-clock periods, a new duty every period
    breath_led #(.PWM_BITS(3), .STEP_PERIODS(1)) dut_b (
        .CLK_50MHz(clk), .reset_n(rst_b), .enable(en_b), .led(led_b));
    // Defaults
    breath_led dut_c (
        .CLK_50MHz(clk), .reset_n(rst_c), .enable(en_c), .led(led_c));

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    typedef struct {
        logic en;
        int   exp_high;
    } vec_t;
    vec_t vecs[66];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference duty for a given step index: triangle wave 0..mx..0 of period 2*mx
    function automatic int tri_duty(input int step, input int mx);
        int p;
        p = step % (2 * mx);
        return (p <= mx) ? p : 2 * mx - p;
    endfunction

    function automatic logic led_of(input int sel);
        case (sel)
            0:       return led_a;
            1:       return led_b;
            default: return led_c;
        endcase
    endfunction

    // Runs a number of clock edges, sampling the selected LED 1 ns after each
    // edge; counts high cycles and low-to-high transitions.
    task automatic run_window(input int sel, input int edges, output int highs, output int rises);
        logic prev, cur;
        prev  = 1'b0;
        highs = 0;
        rises = 0;
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
            cur = led_of(sel);
            if (cur) highs++;
            if (cur && !prev) rises++;
            prev = cur;
        end
    endtask

    initial begin
        int h, r, h1, h2, k, e;

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;

        // Reset held for 40 ns with enable high
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("reset_led_a", int'(led_a), 0);
            check("reset_led_c", int'(led_c), 0);
        end
        rst_a = 1'b1;
        check("reset_duty_a", int'(dut_a.duty_q), 0);
        check("reset_dir_a", int'(dut_a.dir_q), int'(DIR_UP));

        // Ramp table for dut_a, with a two-period freeze at period boundaries
        k = 0;
        for (int i = 0; i < 66; i++) begin
            vecs[i].en = !(i == 10 || i == 11);
            if (vecs[i].en) begin
                vecs[i].exp_high = tri_duty(k / 2, 15);
                k++;
            end else begin
                vecs[i].exp_high = 0;
            end
        end
        for (int i = 0; i < 66; i++) begin
            en_a = vecs[i].en;
            exp_q.push_back(vecs[i].exp_high);
            run_window(0, 16, h, r);
            e = exp_q.pop_front();
            check($sformatf("ramp_high[%0d]", i), h, e);
            check($sformatf("ramp_rises[%0d]", i), r, (e > 0) ? 1 : 0);
        end

        // STEP_PERIODS=1, PWM_BITS=3: duty changes every 8 clocks, period 14 steps
        rst_b = 1'b1;
        for (int i = 0; i < 31; i++) begin
            exp_q.push_back(tri_duty(i, 7));
            run_window(1, 8, h, r);
            check($sformatf("step1_high[%0d]", i), h, exp_q.pop_front());
        end

        // Reset mid-period at duty 3: LED drops asynchronously, ramp restarts at 0 upward
        run_window(1, 2, h, r);
        check("pre_reset_led_b", int'(led_b), 1);
        #2 rst_b = 1'b0;
        #1;
        check("async_reset_led_b", int'(led_b), 0);
        check("async_reset_duty_b", int'(dut_b.duty_q), 0);
        check("async_reset_dir_b", int'(dut_b.dir_q), int'(DIR_UP));
        @(posedge clk);
        #1;
        check("held_reset_led_b", int'(led_b), 0);
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(i);
            run_window(1, 8, h, r);
            check($sformatf("restart_high[%0d]", i), h, exp_q.pop_front());
        end

        // Defaults for 48 periods (~1 ms): duty stays tiny, no mid-period glitches
        rst_c = 1'b1;
        for (int p = 0; p < 48; p++) begin
            exp_q.push_back(tri_duty(p / 25, 1023));
            run_window(2, 1024, h, r);
            e = exp_q.pop_front();
            check($sformatf("dflt_high[%0d]", p), h, e);
            check($sformatf("dflt_rises[%0d]", p), r, (e > 0) ? 1 : 0);
        end

        // Freeze for 100 us five clocks into period 48 (duty 1)
        run_window(2, 5, h1, r);
        en_c = 1'b0;
        run_window(2, 1, h, r);
        check("freeze_led_next_edge", int'(led_c), 0);
        run_window(2, 4999, h, r);
        check("freeze_led_highs", h, 0);
        check("freeze_pwm_cnt", int'(dut_c.u_pwm.pwm_cnt_q), 5);
        check("freeze_step_cnt", int'(dut_c.step_cnt_q), 48 % 25);
        check("freeze_duty", int'(dut_c.duty_q), 1);
        en_c = 1'b1;
        exp_q.push_back(tri_duty(48 / 25, 1023));
        run_window(2, 1019, h2, r);
        check("split_period_high", h1 + h2, exp_q.pop_front());
        for (int p = 49; p < 51; p++) begin
            exp_q.push_back(tri_duty(p / 25, 1023));
            run_window(2, 1024, h, r);
            check($sformatf("resume_high[%0d]", p), h, exp_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/breath_led.md
# breath_led

Breathing-LED driver for the stopwatch status indicator. It generates a PWM waveform whose duty cycle ramps linearly up, then down, continuously, so the LED appears to "breathe". It runs from the 50 MHz board clock. An `enable` input freezes the pattern and blanks the LED.

## Interface
Parameters:
- `PWM_BITS`, default 10: width of the PWM counter and duty register. The PWM period is 2^PWM_BITS clocks (1024 clocks = 20.48 µs).
- `STEP_PERIODS`, default 25: number of complete PWM periods per duty step. Must be ≥1.
- At defaults, a full ramp (0→1023) is about 0.52 s and a full breath (up + down) is about 1.05 s.

Ports:
- `CLK_50MHz`, in, 1: the single system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: 1 runs the breathing pattern; 0 freezes all state and forces the LED off.
- `led`, out, 1: PWM LED drive, active-high, registered.

## Operation
State registers:
- `pwm_cnt` (PWM_BITS wide)
- `step_cnt` (0..STEP_PERIODS-1)
- `duty` (PWM_BITS wide)
- `dir` (1 = ramping up)
- `led`

Reset (asynchronous, `reset_n`=0): `pwm_cnt`=0, `step_cnt`=0, `duty`=0, `dir`=1 (up), `led`=0.

While `enable`=1, on each clock:
- `pwm_cnt` increments and wraps from 2^PWM_BITS−1 to 0.
- Each wrap of `pwm_cnt` to 0 is the period tick. On a period tick, `step_cnt` increments and wraps from STEP_PERIODS−1 to 0.
- The step tick is a period tick on which `step_cnt` wraps. On a step tick, `duty` updates as follows:
  - Up direction: if `duty`=MAX (2^PWM_BITS−1), set `dir`=0 and `duty`=MAX−1. Otherwise `duty`+1.
  - Down direction: if `duty`=0, set `dir`=1 and `duty`=1. Otherwise `duty`−1.
- `duty` changes only at period boundaries. No PWM period ever mixes two duty values.
- `led` is registered as (`pwm_cnt` < `duty`), using the pre-increment `pwm_cnt`.
  - `duty`=0 keeps `led` constantly 0.
  - `duty`=MAX gives MAX high cycles per period (never 100%).

While `enable`=0:
- `pwm_cnt`, `step_cnt`, `duty` and `dir` hold their values.
- `led` is registered to 0.
- When `enable` returns to 1, operation resumes from the held state. Nothing re-initialises.

Duty sequence: 0,1,…,MAX,MAX−1,…,1,0,1,… Each value is held for STEP_PERIODS PWM periods. Each endpoint is visited once per turnaround.

## Timing
- `led` has 1-cycle latency from the compare. `enable` falling forces `led`=0 on the next rising edge.
- `enable` rising: the first `led` reflects the held `pwm_cnt`/`duty` one cycle later.
- Reset assertion clears `led` immediately (asynchronously). Release is synchronous to the next edge. The first count occurs on the first edge with `reset_n`=1.
- Reset mid-ramp: the pattern restarts from `duty`=0, direction up.
- Comparison is unsigned. All counters wrap modulo their width. There is no arithmetic overflow because the endpoints are explicitly handled.

## Structure
- Shared package `breath_led_pkg`: default `PWM_BITS`, default `STEP_PERIODS`, and a `dir_t` enum (`DIR_DOWN`=0, `DIR_UP`=1).
- One sub-module, `breath_led_pwm`: holds `pwm_cnt`, the compare and the `led` register, and emits the period tick. It takes `duty` and `enable` as inputs.
- The top level holds `step_cnt`, `duty` and `dir`.

## Test plan
- Reset: hold `reset_n`=0 for 40 ns with `enable`=1. Required: `led`=0 throughout, and `duty`=0 and `dir`=up after release.
- Ramp check: set PWM_BITS=4, STEP_PERIODS=2. Count `led` high cycles per 16-clock period. Required: 0,0,1,1,2,2,…,15,15,14,14,…,0,0,1,1. This confirms turnaround at 15 and at 0.
- Defaults, `enable`=1 for 1 ms after reset. Required: duty stays ≤ 2 (48 periods completed); `led` high ≤ 2 cycles per 1024-clock period; no glitches mid-period.
- Freeze: drop `enable` for 100 µs mid-pattern. Required:
  - `led`=0 from the next edge.
  - `pwm_cnt`, `step_cnt` and `duty` are unchanged.
  - After re-enable, the high-cycle sequence continues exactly where it stopped.
- Reset mid-operation at a nonzero duty (small params). Required: `led` drops asynchronously, and the pattern restarts from duty 0, direction up.
- STEP_PERIODS=1, PWM_BITS=3. Required: duty changes every 8 clocks, giving the sequence 0..7..0 repeating with period 14 steps.
